vrom_arbiter: RTL and testbench

//  Shares one synchronous image ROM port between the function-2 and function-3 GPUs.

---
 rtl/vrom_arbiter_if.sv | 41 ++++
 rtl/vrom_arbiter.sv | 136 +++++++++++++
 tb/tb_vrom_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrom_arbiter_if.sv
// Port bundle between the two GPU read clients, the arbiter and the image ROM.
// The arbiter side uses the slave modport; the GPU/ROM side (or a bench) uses master.
interface vrom_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 3
);
  // Handshake: a client raises req with addr/index stable and holds them until it sees
  // gnt high in the same cycle; gnt is combinational and means the request is taken
  // at the next rising edge. Dropping req before gnt cancels the request. valid is a
  // one-cycle pulse qualifying data; there is no back-pressure on the return path.
  logic              f2_req;
  logic [ADDR_W-1:0] f2_addr;
  logic [IDX_W-1:0]  f2_index;
  logic              f2_gnt;
  logic              f2_valid;
  logic [DATA_W-1:0] f2_data;

  logic              f3_req;
  logic [ADDR_W-1:0] f3_addr;
  logic              f3_gnt;
  logic              f3_valid;
  logic [DATA_W-1:0] f3_data;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_index;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  f2_req, f2_addr, f2_index, f3_req, f3_addr, rom_data,
    output f2_gnt, f2_valid, f2_data, f3_gnt, f3_valid, f3_data,
    output rom_en, rom_addr, rom_index
  );

  modport master (
    output f2_req, f2_addr, f2_index, f3_req, f3_addr, rom_data,
    input  f2_gnt, f2_valid, f2_data, f3_gnt, f3_valid, f3_data,
    input  rom_en, rom_addr, rom_index
  );
endinterface

// File: rtl/vrom_arbiter.sv
// Two-client arbiter for the shared image ROM: foreground priority with a bounded
// starvation streak for the background client, round-robin when neither is foreground.
module vrom_arbiter #(
  parameter int               ADDR_W     = 8,
  parameter int               IDX_W      = 3,
  parameter int               DATA_W     = 3,
  parameter int               ROM_LAT    = 1,
  parameter int               MAX_STREAK = 4,
  parameter logic [IDX_W-1:0] F3_INDEX   = '0
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [1:0]  func_index,
  vrom_arbiter_if.slave bus,
  output logic [3:0]  dbg_streak,
  output logic        dbg_last_winner
);

  typedef enum logic {OWN_F2 = 1'b0, OWN_F3 = 1'b1} owner_e;

  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

  logic [3:0]   streak_q;
  logic [3:0]   streak_nxt;
  logic [3:0]   eff_streak;
  logic [1:0]   func_q;
  owner_e       last_winner;
  owner_e       rom_owner;
  logic         win2;
  logic         win3;
  logic         fg2;
  logic         fg3;
  logic         bg_req;
  logic         bg_gnt;
  logic         fg_gnt;

  logic [ROM_LAT-1:0] tag_v;
  owner_e             tag_o [ROM_LAT];

  // A function switch restarts the streak for the grant decided in the switch cycle.
  always_comb begin
    fg2        = (func_index == 2'd1);
    fg3        = (func_index == 2'd2);
    eff_streak = (func_index != func_q) ? 4'd0 : streak_q;
    win2       = 1'b0;
    win3       = 1'b0;
    if (rst_n) begin
      if (bus.f2_req && bus.f3_req) begin
        if (fg2) begin
          if (eff_streak < MAX_S) win2 = 1'b1;
          else                    win3 = 1'b1;
        end else if (fg3) begin
          if (eff_streak < MAX_S) win3 = 1'b1;
          else                    win2 = 1'b1;
        end else if (last_winner == OWN_F3) begin
          win2 = 1'b1;
        end else begin
          win3 = 1'b1;
        end
      end else begin
        win2 = bus.f2_req;
        win3 = bus.f3_req;
      end
    end
  end

  always_comb begin
    bg_req     = fg2 ? bus.f3_req : (fg3 ? bus.f2_req : 1'b0);
    bg_gnt     = fg2 ? win3 : (fg3 ? win2 : 1'b0);
    fg_gnt     = fg2 ? win2 : (fg3 ? win3 : 1'b0);
    streak_nxt = 4'd0;
    if (bg_req && !bg_gnt) begin
      if (fg_gnt) streak_nxt = (eff_streak < MAX_S) ? eff_streak + 4'd1 : MAX_S;
      else        streak_nxt = eff_streak;
    end
  end

  assign bus.f2_gnt      = win2;
  assign bus.f3_gnt      = win3;
  assign dbg_streak      = streak_q;
  assign dbg_last_winner = last_winner;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      streak_q      <= 4'd0;
      func_q        <= 2'd0;
      last_winner   <= OWN_F3;
      rom_owner     <= OWN_F2;
      bus.rom_en    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.rom_index <= '0;
      bus.f2_valid  <= 1'b0;
      bus.f2_data   <= '0;
      bus.f3_valid  <= 1'b0;
      bus.f3_data   <= '0;
      tag_v         <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_o[i] <= OWN_F2;
    end else begin
      streak_q   <= streak_nxt;
      func_q     <= func_index;
      bus.rom_en <= win2 | win3;
      if (win2) begin
        last_winner   <= OWN_F2;
        rom_owner     <= OWN_F2;
        bus.rom_addr  <= bus.f2_addr;
        bus.rom_index <= bus.f2_index;
      end else if (win3) begin
        last_winner   <= OWN_F3;
        rom_owner     <= OWN_F3;
        bus.rom_addr  <= bus.f3_addr;
        bus.rom_index <= F3_INDEX;
      end

      // Owner tag trails rom_en so it emerges in the cycle rom_data is valid.
      tag_v[0] <= bus.rom_en;
      tag_o[0] <= rom_owner;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end

      bus.f2_valid <= 1'b0;
      bus.f3_valid <= 1'b0;
      if (tag_v[ROM_LAT-1]) begin
        if (tag_o[ROM_LAT-1] == OWN_F3) begin
          bus.f3_valid <= 1'b1;
          bus.f3_data  <= bus.rom_data;
        end else begin
          bus.f2_valid <= 1'b1;
          bus.f2_data  <= bus.rom_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_vrom_arbiter.sv
// Bench for vrom_arbiter: scoreboarded ROM reads, grant-order checks, reset kill of
// in-flight reads.
module tb_vrom_arbiter;

  localparam int         LAT = 1;
  localparam logic [2:0] F3I = 3'd0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] func_index;
  logic [3:0] dbg_streak;
  logic       dbg_last_winner;

  vrom_arbiter_if #(.ADDR_W(8), .IDX_W(3), .DATA_W(3)) bus ();

  vrom_arbiter #(
    .ADDR_W(8), .IDX_W(3), .DATA_W(3), .ROM_LAT(LAT), .MAX_STREAK(4), .F3_INDEX(F3I)
  ) dut (
    .sysclk(clk),
    .rst_n(rst_n),
    .func_index(func_index),
    .bus(bus),
    .dbg_streak(dbg_streak),
    .dbg_last_winner(dbg_last_winner)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_word(input logic [2:0] idx, input logic [7:0] a);
    return a[2:0] ^ a[5:3] ^ idx ^ {1'b0, a[7:6]};
  endfunction

  // ROM model: word for (index, addr) appears LAT cycles after rom_en.
  logic [2:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= rom_word(bus.rom_index, bus.rom_addr);
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign bus.rom_data = rp[LAT-1];

  int checks = 0;
  int errors = 0;
  logic [2:0]  exp_q2 [$];
  logic [2:0]  exp_q3 [$];
  logic [10:0] rom_q  [$];
  int          gnt_log [$];
  int          v3_cyc [$];
  int          v2_cnt = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("one_gnt", 32'(bus.f2_gnt & bus.f3_gnt), 0);
      if (!rst_n) check("gnt_in_reset", 32'(bus.f2_gnt | bus.f3_gnt), 0);
      if (bus.rom_en) begin
        check("rom_en_expected", 32'(rom_q.size() != 0), 1);
        if (rom_q.size() != 0) check("rom_idx_addr", 32'({bus.rom_index, bus.rom_addr}), 32'(rom_q.pop_front()));
      end
      if (bus.f2_valid) begin
        v2_cnt++;
        check("f2_valid_expected", 32'(exp_q2.size() != 0), 1);
        if (exp_q2.size() != 0) check("f2_data", 32'(bus.f2_data), 32'(exp_q2.pop_front()));
      end
      if (bus.f3_valid) begin
        v3_cyc.push_back(cyc);
        check("f3_valid_expected", 32'(exp_q3.size() != 0), 1);
        if (exp_q3.size() != 0) check("f3_data", 32'(bus.f3_data), 32'(exp_q3.pop_front()));
      end
      if (bus.f2_gnt) begin
        exp_q2.push_back(rom_word(bus.f2_index, bus.f2_addr));
        rom_q.push_back({bus.f2_index, bus.f2_addr});
        gnt_log.push_back(0);
      end
      if (bus.f3_gnt) begin
        exp_q3.push_back(rom_word(F3I, bus.f3_addr));
        rom_q.push_back({F3I, bus.f3_addr});
        gnt_log.push_back(1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.f2_req = 1'b0;
    bus.f3_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_q2.delete();
    exp_q3.delete();
    rom_q.delete();
    gnt_log.delete();
  endtask

  task automatic drain_check(input string tag);
    idle(LAT + 4);
    check({tag, "_q2_drained"}, 32'(exp_q2.size()), 0);
    check({tag, "_q3_drained"}, 32'(exp_q3.size()), 0);
    check({tag, "_rom_drained"}, 32'(rom_q.size()), 0);
  endtask

  // Each client holds req until granted, then presents its next address.
  task automatic stream(input int cycles, input int n2, input int n3, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [2:0] idx2, input int sw_cyc,
                        input logic [1:0] sw_val);
    int c2;
    int c3;
    c2 = 0;
    c3 = 0;
    for (int k = 0; k < cycles; k++) begin
      if (k == sw_cyc) func_index = sw_val;
      bus.f2_req   = (c2 < n2);
      bus.f2_addr  = b2 + 8'(c2);
      bus.f2_index = idx2;
      bus.f3_req   = (c3 < n3);
      bus.f3_addr  = b3 + 8'(c3);
      @(negedge clk);
      if (bus.f2_gnt) c2++;
      if (bus.f3_gnt) c3++;
      @(posedge clk);
      #1;
    end
    bus.f2_req = 1'b0;
    bus.f3_req = 1'b0;
  endtask

  initial begin
    int v2_base;
    rst_n        = 1'b0;
    func_index   = 2'd0;
    bus.f2_req   = 1'b1;
    bus.f2_addr  = 8'h00;
    bus.f2_index = 3'd0;
    bus.f3_req   = 1'b1;
    bus.f3_addr  = 8'h00;

    // Reset state, with both requests high while in reset.
    idle(2);
    @(negedge clk);
    check("rst_f2_gnt", 32'(bus.f2_gnt), 0);
    check("rst_f3_gnt", 32'(bus.f3_gnt), 0);
    check("rst_rom_en", 32'(bus.rom_en), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_rom_index", 32'(bus.rom_index), 0);
    check("rst_valids", 32'({bus.f2_valid, bus.f3_valid}), 0);
    check("rst_datas", 32'({bus.f2_data, bus.f3_data}), 0);
    check("rst_streak", 32'(dbg_streak), 0);
    check("rst_last_winner", 32'(dbg_last_winner), 1);
    @(posedge clk);
    #1;
    do_reset();

    // Single f2 read: grant, issue, return latency.
    bus.f2_req   = 1'b1;
    bus.f2_addr  = 8'h2A;
    bus.f2_index = 3'd5;
    @(negedge clk);
    check("t1_f2_gnt", 32'(bus.f2_gnt), 1);
    @(posedge clk);
    #1;
    bus.f2_req = 1'b0;
    @(negedge clk);
    check("t1_rom_en", 32'(bus.rom_en), 1);
    check("t1_rom_addr", 32'(bus.rom_addr), 32'h2A);
    check("t1_rom_index", 32'(bus.rom_index), 5);
    @(negedge clk);
    check("t1_valid_c2", 32'(bus.f2_valid), 0);
    @(negedge clk);
    check("t1_valid_c3", 32'(bus.f2_valid), 1);
    check("t1_data_c3", 32'(bus.f2_data), 32'(rom_word(3'd5, 8'h2A)));
    @(posedge clk);
    #1;
    drain_check("t1");

    // Foreground f2 with bounded streak: f2 x4 then f3.
    do_reset();
    func_index = 2'd1;
    stream(10, 20, 20, 8'h10, 8'h90, 3'd2, -1, 2'd0);
    for (int i = 0; i < 10; i++)
      check($sformatf("t2_gnt%0d", i), 32'((i < gnt_log.size()) ? gnt_log[i] : 2), 32'(i % 5 == 4));
    drain_check("t2");

    // No foreground: strict alternation starting with f2.
    do_reset();
    func_index = 2'd0;
    stream(8, 20, 20, 8'h40, 8'h80, 3'd6, -1, 2'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_gnt%0d", i), 32'((i < gnt_log.size()) ? gnt_log[i] : 2), 32'(i % 2));
    drain_check("t3");

    // Back-to-back f3 reads at 0,1,2.
    v3_cyc.delete();
    v2_base = v2_cnt;
    stream(4, 0, 3, 8'h00, 8'h00, 3'd0, -1, 2'd0);
    drain_check("t4");
    check("t4_v3_count", 32'(v3_cyc.size()), 3);
    if (v3_cyc.size() == 3) begin
      check("t4_v3_consec1", 32'(v3_cyc[1] - v3_cyc[0]), 1);
      check("t4_v3_consec2", 32'(v3_cyc[2] - v3_cyc[1]), 1);
    end
    check("t4_no_f2_valid", 32'(v2_cnt - v2_base), 0);

    // Reset one edge after a grant kills the reads still in flight.
    do_reset();
    func_index   = 2'd1;
    bus.f2_req   = 1'b1;
    bus.f2_addr  = 8'h15;
    bus.f2_index = 3'd3;
    bus.f3_req   = 1'b1;
    bus.f3_addr  = 8'h22;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rst_n      = 1'b0;
    bus.f2_req = 1'b0;
    bus.f3_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rom_en", 32'(bus.rom_en), 0);
    check("t5_rom_addr", 32'(bus.rom_addr), 0);
    check("t5_rom_index", 32'(bus.rom_index), 0);
    check("t5_valids", 32'({bus.f2_valid, bus.f3_valid}), 0);
    check("t5_datas", 32'({bus.f2_data, bus.f3_data}), 0);
    check("t5_streak", 32'(dbg_streak), 0);
    check("t5_last_winner", 32'(dbg_last_winner), 1);
    check("t5_killed_reads", 32'(exp_q2.size()), 2);
    exp_q2.delete();
    @(posedge clk);
    #1;
    drain_check("t5");

    // Foreground switch 1->2 at streak 3: f2 x3, f3 x4, f2, f3.
    do_reset();
    func_index = 2'd1;
    stream(9, 20, 20, 8'h30, 8'hC0, 3'd1, 3, 2'd2);
    for (int i = 0; i < 9; i++)
      check($sformatf("t6_gnt%0d", i), 32'((i < gnt_log.size()) ? gnt_log[i] : 2),
            32'((i >= 3 && i <= 6) || i == 8));
    drain_check("t6");

    // Random mixed traffic, any foreground.
    for (int r = 0; r < 6; r++) begin
      stream(12, $urandom_range(0, 8), $urandom_range(0, 8), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), $urandom_range(0, 11),
             2'($urandom_range(0, 3)));
      drain_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
